// File: rtl/jt51_float_ser.sv
// jt51_float_ser: serialises a stereo 16-bit pair as 3-bit-exponent/10-bit-mantissa floats
module jt51_float_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        sample,
    input  logic [15:0] left,
    input  logic [15:0] right,
    output logic        so,
    output logic        sh1,
    output logic        sh2
);
    logic [4:0]  r_ct;
    logic        r_first;
    logic [15:0] r_left, r_right, r_sl, r_sr;
    logic        w_load;
    logic [4:0]  w_ct_nx;
    logic [15:0] w_wl, w_wr, w_word;

    // word = {e, m, 3'b0}; e is the smallest 1..7 leaving x[15:8+e] as pure sign
    function automatic logic [15:0] f_enc(input logic [15:0] x);
        logic [2:0]  e;
        logic [15:0] t;
        e = 3'd7;
        for (int k = 7; k >= 1; k--) begin
            t = 16'($signed(x) >>> (8 + k));
            if (t == '0 || t == '1) e = 3'(k);
        end
        t = x >> (e - 3'd1);
        return {e, t[9:0], 3'b000};
    endfunction

    // The first enabled edge after reset acts as a frame load, so the frame starts at slot 0
    always_comb begin
        w_load  = r_first || r_ct == 5'd31;
        w_ct_nx = r_first ? 5'd0 : r_ct + 5'd1;
        w_wl    = w_load ? f_enc(sample ? left : r_left) : r_sl;
        w_wr    = w_load ? f_enc(sample ? right : r_right) : r_sr;
        w_word  = w_ct_nx[4] ? w_wr : w_wl;
    end

    // Holding registers follow sample every clk; slot state and outputs advance on cen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ct    <= '0;
            r_first <= 1'b1;
            r_left  <= '0;
            r_right <= '0;
            r_sl    <= '0;
            r_sr    <= '0;
            so      <= 1'b0;
            sh1     <= 1'b0;
            sh2     <= 1'b0;
        end else begin
            if (sample) begin
                r_left  <= left;
                r_right <= right;
            end
            if (cen) begin
                r_ct    <= w_ct_nx;
                r_first <= 1'b0;
                r_sl    <= w_wl;
                r_sr    <= w_wr;
                so      <= w_word[w_ct_nx[3:0]];
                sh1     <= !w_ct_nx[4] && w_ct_nx[3:0] >= 4'd13;
                sh2     <= w_ct_nx[4] && w_ct_nx[3:0] >= 4'd13;
            end
        end
    end
endmodule
